// File: rtl/req_gnt_pkg.sv
// Shared req/gnt types and default timing constants for the requester and granter sides.
`timescale 1ns/1ps
package req_gnt_pkg;
   typedef enum logic [1:0] {IDLE, REQ, BACKOFF} req_gnt_state_e;

   localparam int DEF_TIMEOUT_CYC = 8;
   localparam int DEF_MAX_RETRY   = 2;
   localparam int DEF_RETRY_GAP   = 2;
endpackage

// File: rtl/req_gnt_if.sv
// Single-bit req/gnt handshake; master is the requester, slave is the granter.
`timescale 1ns/1ps
interface req_gnt_if;
   logic req;
   logic gnt;

   modport master (output req, input gnt);
   modport slave  (input req, output gnt);
endinterface

// File: rtl/req_gnt_timer.sv
// Up-counter with clear/enable; expire flags the enabled edge that completes LIMIT counts.
`timescale 1ns/1ps
module req_gnt_timer #(
   parameter int W     = 4,
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);
   logic [W-1:0] cnt;

   assign expire = en && !clr && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/req_gnt_requester.sv
// Initiator side of the req/gnt handshake with timeout, bounded retry and backoff.
// Define REQ_GNT_ASSERT_EN to compile the embedded protocol assertions and covers.
`timescale 1ns/1ps
module req_gnt_requester
   import req_gnt_pkg::*;
#(
   parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int  MAX_RETRY   = DEF_MAX_RETRY,
   parameter int  RETRY_GAP   = DEF_RETRY_GAP,
   localparam int RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          job_valid,
   output logic          job_ready,
   req_gnt_if.master     bus,
   output logic          done,
   output logic          err,
   output logic [RW-1:0] retry_cnt,
   output logic          spur_gnt
);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam int GAP_W = $clog2(RETRY_GAP + 1);

   req_gnt_state_e state_q, state_d;
   logic           req_q, req_d, done_d, err_d, trail_q;
   logic [RW-1:0]  rcnt_d;
   logic           to_exp, bo_exp;

   req_gnt_timer #(.W(CNT_W), .LIMIT(TIMEOUT_CYC)) u_to (
      .clk(clk), .rst(rst), .clr(state_q != REQ),
      .en(state_q == REQ && !bus.gnt), .expire(to_exp));

   req_gnt_timer #(.W(GAP_W), .LIMIT(RETRY_GAP)) u_bo (
      .clk(clk), .rst(rst), .clr(state_q != BACKOFF),
      .en(state_q == BACKOFF), .expire(bo_exp));

   assign bus.req   = req_q;
   assign job_ready = (state_q == IDLE);

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rcnt_d  = retry_cnt;
      case (state_q)
         IDLE: if (job_valid) begin
            state_d = REQ;
            req_d   = 1'b1;
            rcnt_d  = '0;
         end
         // gnt outranks a timeout landing on the same edge
         REQ: if (bus.gnt) begin
            state_d = IDLE;
            req_d   = 1'b0;
            done_d  = 1'b1;
         end else if (to_exp) begin
            req_d = 1'b0;
            if (retry_cnt < RW'(MAX_RETRY)) begin
               state_d = BACKOFF;
               rcnt_d  = retry_cnt + 1'b1;
            end else begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end
         BACKOFF: if (bo_exp) begin
            state_d = REQ;
            req_d   = 1'b1;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         retry_cnt <= '0;
         trail_q   <= 1'b0;
         spur_gnt  <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         done      <= done_d;
         err       <= err_d;
         retry_cnt <= rcnt_d;
         // the granter echoes req one cycle late, so one gnt after req falls is legal
         trail_q   <= (state_q == REQ) && (state_d != REQ);
         if (bus.gnt && state_q != REQ && !trail_q) spur_gnt <= 1'b1;
      end
   end

`ifdef REQ_GNT_ASSERT_EN
   a_req_hold: assert property (@(posedge clk) disable iff (rst)
      (bus.req && !bus.gnt && !to_exp) |=> bus.req);
   a_excl: assert property (@(posedge clk) disable iff (rst) !(done && err));
   a_done: assert property (@(posedge clk) disable iff (rst)
      done |-> $past(bus.req && bus.gnt));
   c_gnt: cover property (@(posedge clk) disable iff (rst)
      bus.req ##[1:TIMEOUT_CYC] bus.gnt);
   c_err: cover property (@(posedge clk) disable iff (rst) err);
`endif
endmodule

// File: tb/tb_req_gnt_requester.sv
// Directed bench for req_gnt_requester against a gnt <= req granter model.
`timescale 1ns/1ps
module tb_req_gnt_requester;
   logic       clk = 1'b0, rst = 1'b1, job_valid = 1'b0;
   logic       gnt_en = 1'b1, gnt_force = 1'b0, gnt_auto;
   logic       job_ready, done, err, spur_gnt;
   logic [1:0] retry_cnt;
   int         checks = 0, errors = 0;

   req_gnt_if bus();
   assign bus.gnt = gnt_en ? gnt_auto : gnt_force;

   always #1 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) gnt_auto <= 1'b0;
      else     gnt_auto <= bus.req;

   req_gnt_requester #(.TIMEOUT_CYC(8), .MAX_RETRY(2), .RETRY_GAP(2)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .bus(bus), .done(done), .err(err), .retry_cnt(retry_cnt), .spur_gnt(spur_gnt));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      tick(); tick();
      checks++;
      if ({bus.req, done, err, retry_cnt, spur_gnt, job_ready} !== 7'b0000001) begin
         errors++;
         $display("FAIL reset_state: req=%b done=%b err=%b retry=%0d spur=%b ready=%b, want 0 0 0 0 0 1",
                  bus.req, done, err, retry_cnt, spur_gnt, job_ready);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      gnt_en = 1'b1; job_valid = 1'b1;
      tick(); job_valid = 1'b0;
      checks++;
      if (bus.req !== 1'b1 || job_ready !== 1'b0) begin
         errors++; $display("FAIL single_accept: req=%b ready=%b, want 1 0", bus.req, job_ready);
      end
      tick();
      checks++;
      if (bus.req !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL single_wait: req=%b done=%b, want 1 0", bus.req, done);
      end
      tick();
      checks++;
      if ({bus.req, done, err, retry_cnt} !== 5'b01000) begin
         errors++; $display("FAIL single_done: req=%b done=%b err=%b retry=%0d, want 0 1 0 0",
                            bus.req, done, err, retry_cnt);
      end
      tick();
      checks++;
      if (done !== 1'b0 || spur_gnt !== 1'b0 || job_ready !== 1'b1) begin
         errors++; $display("FAIL single_after: done=%b spur=%b ready=%b, want 0 0 1", done, spur_gnt, job_ready);
      end
   endtask

   task automatic test_timeout_err();
      logic       exp_req;
      logic [1:0] exp_rc;
      gnt_en = 1'b0; gnt_force = 1'b0; job_valid = 1'b1;
      for (int c = 0; c < 30; c++) begin
         tick();
         if (c == 0) job_valid = 1'b0;
         exp_req = (c < 8) || (c >= 10 && c < 18) || (c >= 20 && c < 28);
         exp_rc  = (c < 8) ? 2'd0 : (c < 18) ? 2'd1 : 2'd2;
         checks++;
         if (bus.req !== exp_req || retry_cnt !== exp_rc || done !== 1'b0 || err !== (c == 28)) begin
            errors++;
            $display("FAIL timeout_c%0d: req=%b retry=%0d done=%b err=%b, want %b %0d 0 %b",
                     c, bus.req, retry_cnt, done, err, exp_req, exp_rc, (c == 28));
         end
      end
      gnt_en = 1'b1;
   endtask

   task automatic test_late_gnt();
      gnt_en = 1'b0; gnt_force = 1'b0; job_valid = 1'b1;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (c == 0) job_valid = 1'b0;
         checks++;
         if (bus.req !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL late_wait_c%0d: req=%b done=%b, want 1 0", c, bus.req, done);
         end
         if (c == 7) gnt_force = 1'b1;
      end
      tick(); gnt_force = 1'b0;
      checks++;
      if ({bus.req, done, err, retry_cnt} !== 5'b01000) begin
         errors++; $display("FAIL late_done: req=%b done=%b err=%b retry=%0d, want 0 1 0 0",
                            bus.req, done, err, retry_cnt);
      end
      tick();
      checks++;
      if (bus.req !== 1'b0 || done !== 1'b0 || spur_gnt !== 1'b0 || job_ready !== 1'b1) begin
         errors++; $display("FAIL late_after: req=%b done=%b spur=%b ready=%b, want 0 0 0 1",
                            bus.req, done, spur_gnt, job_ready);
      end
      gnt_en = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp_req  = 7'b0011011;
      logic [6:0] exp_done = 7'b0100100;
      int         ndone = 0;
      gnt_en = 1'b1; job_valid = 1'b1;
      for (int c = 0; c < 7; c++) begin
         tick();
         if (c == 5) job_valid = 1'b0;
         if (done === 1'b1) ndone++;
         checks++;
         if (bus.req !== exp_req[c] || done !== exp_done[c] || spur_gnt !== 1'b0) begin
            errors++;
            $display("FAIL b2b_c%0d: req=%b done=%b spur=%b, want %b %b 0",
                     c, bus.req, done, spur_gnt, exp_req[c], exp_done[c]);
         end
      end
      checks++;
      if (ndone != 2) begin
         errors++; $display("FAIL b2b_done_count: got %0d, want 2", ndone);
      end
   endtask

   task automatic test_spur();
      gnt_en = 1'b0; gnt_force = 1'b0;
      tick(); tick();
      checks++;
      if (spur_gnt !== 1'b0) begin
         errors++; $display("FAIL spur_pre: spur=%b, want 0", spur_gnt);
      end
      gnt_force = 1'b1; tick(); gnt_force = 1'b0;
      checks++;
      if (spur_gnt !== 1'b1) begin
         errors++; $display("FAIL spur_set: spur=%b, want 1", spur_gnt);
      end
      gnt_en = 1'b1; job_valid = 1'b1;
      tick(); job_valid = 1'b0;
      tick(); tick();
      checks++;
      if (done !== 1'b1 || spur_gnt !== 1'b1) begin
         errors++; $display("FAIL spur_sticky: done=%b spur=%b, want 1 1", done, spur_gnt);
      end
      tick(); tick();
   endtask

   task automatic test_rst_mid();
      gnt_en = 1'b0; gnt_force = 1'b0; job_valid = 1'b1;
      tick(); job_valid = 1'b0;
      tick(); tick();
      checks++;
      if (bus.req !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: req=%b, want 1", bus.req);
      end
      rst = 1'b1;
      #0.5;
      checks++;
      if (bus.req !== 1'b0 || spur_gnt !== 1'b0) begin
         errors++; $display("FAIL rstmid_async: req=%b spur=%b, want 0 0", bus.req, spur_gnt);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (done !== 1'b0 || err !== 1'b0 || bus.req !== 1'b0) begin
            errors++; $display("FAIL rstmid_hold_c%0d: req=%b done=%b err=%b, want 0 0 0", c, bus.req, done, err);
         end
      end
      gnt_en = 1'b1; rst = 1'b0; job_valid = 1'b1;
      tick(); job_valid = 1'b0;
      checks++;
      if (bus.req !== 1'b1) begin
         errors++; $display("FAIL rstmid_accept: req=%b, want 1", bus.req);
      end
      tick(); tick();
      checks++;
      if (bus.req !== 1'b0 || done !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL rstmid_done: req=%b done=%b err=%b, want 0 1 0", bus.req, done, err);
      end
      tick();
      checks++;
      if (done !== 1'b0 || spur_gnt !== 1'b0) begin
         errors++; $display("FAIL rstmid_after: done=%b spur=%b, want 0 0", done, spur_gnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_timeout_err();
      test_late_gnt();
      test_back_to_back();
      test_spur();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
